// File: rtl/wr_port_arbiter.sv
// rtl/wr_port_arbiter.sv - shares the register-bank write port among N_REQ requesters
// Define WR_PORT_ARB_RR_EN for round-robin arbitration; undefined gives fixed priority (lowest index wins).
module wr_port_arbiter #(
  parameter int N_REQ = 3,
  parameter int DW    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [2*N_REQ-1:0]  i_addr,
  input  logic [DW*N_REQ-1:0] i_wdata,
  input  logic                i_stall,
  output logic [N_REQ-1:0]    o_gnt,
  output logic                o_err,
  output logic                o_we,
  output logic [1:0]          o_addr,
  output logic [DW-1:0]       o_wdata,
  output logic                o_busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [1:0]        addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [N_REQ-1:0]  elig;
  logic              found;
  int                sel;

`ifdef WR_PORT_ARB_RR_EN
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  int            idx;
`endif

  // The requester being acknowledged still holds req this cycle, so it is masked out.
  assign elig   = (state_q == GRANT) ? (i_req & ~gnt_q) : i_req;
  assign o_busy = |elig;

  always_comb begin : pick
    found = 1'b0;
    sel   = 0;
`ifdef WR_PORT_ARB_RR_EN
    idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
`else
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        sel   = i;
      end
    end
`endif
  end

  always_comb begin : next
    state_d = IDLE;
    gnt_d   = '0;
    err_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef WR_PORT_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    if (found && !i_stall) begin
      state_d    = GRANT;
      gnt_d[sel] = 1'b1;
      addr_d     = i_addr[2*sel +: 2];
      wdata_d    = i_wdata[DW*sel +: DW];
      // Unmapped address is still acknowledged so the requester cannot hang.
      we_d       = (addr_d != 2'b11);
      err_d      = (addr_d == 2'b11);
`ifdef WR_PORT_ARB_RR_EN
      ptr_d      = (sel == N_REQ - 1) ? '0 : PW'(sel + 1);
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 2'b00;
      wdata_q <= '0;
`ifdef WR_PORT_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef WR_PORT_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign o_gnt   = gnt_q;
  assign o_err   = err_q;
  assign o_we    = we_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb/tb_wr_port_arbiter.sv - scoreboard bench for wr_port_arbiter (N_REQ=3, DW=8)
// Stimulus words are {rst, stall, req[2:0]}; expectations are {gnt, err, we, addr, wdata}.
module tb_wr_port_arbiter;

  typedef struct packed {
    logic [2:0] gnt;
    logic       err;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
  } exp_t;

  logic        i_clk;
  logic        i_rst;
  logic [2:0]  i_req;
  logic [5:0]  i_addr;
  logic [23:0] i_wdata;
  logic        i_stall;
  logic [2:0]  o_gnt;
  logic        o_err;
  logic        o_we;
  logic [1:0]  o_addr;
  logic [7:0]  o_wdata;
  logic        o_busy;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  wr_port_arbiter #(.N_REQ(3), .DW(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_stall(i_stall), .o_gnt(o_gnt), .o_err(o_err),
    .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic exp_t mk(logic [2:0] g, logic e, logic w, logic [1:0] a, logic [7:0] d);
    return {g, e, w, a, d};
  endfunction

  function automatic exp_t obs();
    return {o_gnt, o_err, o_we, o_addr, o_wdata};
  endfunction

  task automatic test_reset();
    logic [4:0] st [2];
    exp_t       ex [2];
    exp_t       want;
    i_addr  = 6'b11_11_11;
    i_wdata = 24'hFFFFFF;
    st = '{5'b10111, 5'b10000};
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00)};
    foreach (st[j]) begin
      {i_rst, i_stall, i_req} = st[j];
      sb_q.push_back(ex[j]);
      @(posedge i_clk); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", j, obs(), want);
      end
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_single();
    logic [4:0] st [4];
    exp_t       ex [4];
    exp_t       want;
    i_addr  = 6'b00_00_10;
    i_wdata = 24'h0000A5;
    st = '{5'b10000, 5'b00001, 5'b00001, 5'b00000};
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b001, 1'b0, 1'b1, 2'b10, 8'hA5),
           mk(3'b000, 1'b0, 1'b0, 2'b10, 8'hA5), mk(3'b000, 1'b0, 1'b0, 2'b10, 8'hA5)};
    foreach (st[j]) begin
      {i_rst, i_stall, i_req} = st[j];
      sb_q.push_back(ex[j]);
      @(posedge i_clk); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL single[%0d]: got %h expected %h", j, obs(), want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] st [5];
    exp_t       ex [5];
    exp_t       want;
    i_addr  = 6'b00_00_01;
    i_wdata = 24'h00005A;
    st = '{5'b10000, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b001, 1'b0, 1'b1, 2'b01, 8'h5A),
           mk(3'b000, 1'b0, 1'b0, 2'b01, 8'h5A), mk(3'b001, 1'b0, 1'b1, 2'b01, 8'h5A),
           mk(3'b000, 1'b0, 1'b0, 2'b01, 8'h5A)};
    foreach (st[j]) begin
      {i_rst, i_stall, i_req} = st[j];
      sb_q.push_back(ex[j]);
      @(posedge i_clk); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", j, obs(), want);
      end
    end
  endtask

  task automatic test_all_three();
    logic [4:0] st [6];
    exp_t       ex [6];
    exp_t       want;
    i_addr  = {2'b10, 2'b01, 2'b00};
    i_wdata = {8'h33, 8'h22, 8'h11};
    st = '{5'b10000, 5'b00111, 5'b00111, 5'b00111, 5'b00111, 5'b00000};
`ifdef WR_PORT_ARB_RR_EN
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b001, 1'b0, 1'b1, 2'b00, 8'h11),
           mk(3'b010, 1'b0, 1'b1, 2'b01, 8'h22), mk(3'b100, 1'b0, 1'b1, 2'b10, 8'h33),
           mk(3'b001, 1'b0, 1'b1, 2'b00, 8'h11), mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h11)};
`else
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b001, 1'b0, 1'b1, 2'b00, 8'h11),
           mk(3'b010, 1'b0, 1'b1, 2'b01, 8'h22), mk(3'b001, 1'b0, 1'b1, 2'b00, 8'h11),
           mk(3'b010, 1'b0, 1'b1, 2'b01, 8'h22), mk(3'b000, 1'b0, 1'b0, 2'b01, 8'h22)};
`endif
    foreach (st[j]) begin
      {i_rst, i_stall, i_req} = st[j];
      sb_q.push_back(ex[j]);
      @(posedge i_clk); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL all_three[%0d]: got %h expected %h", j, obs(), want);
      end
    end
  endtask

  task automatic test_err();
    logic [4:0] st [4];
    exp_t       ex [4];
    exp_t       want;
    i_addr  = 6'b00_11_00;
    i_wdata = 24'h003C00;
    st = '{5'b10000, 5'b00010, 5'b00010, 5'b00000};
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b010, 1'b1, 1'b0, 2'b11, 8'h3C),
           mk(3'b000, 1'b0, 1'b0, 2'b11, 8'h3C), mk(3'b000, 1'b0, 1'b0, 2'b11, 8'h3C)};
    foreach (st[j]) begin
      {i_rst, i_stall, i_req} = st[j];
      sb_q.push_back(ex[j]);
      @(posedge i_clk); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL err[%0d]: got %h expected %h", j, obs(), want);
      end
    end
  endtask

  task automatic test_stall();
    logic [4:0] st [7];
    exp_t       ex [7];
    logic       bx [7];
    exp_t       want;
    i_addr  = {2'b10, 2'b01, 2'b00};
    i_wdata = {8'h55, 8'h44, 8'h00};
    st = '{5'b10000, 5'b01110, 5'b01110, 5'b01110, 5'b00110, 5'b00100, 5'b00000};
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00),
           mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00),
           mk(3'b010, 1'b0, 1'b1, 2'b01, 8'h44), mk(3'b100, 1'b0, 1'b1, 2'b10, 8'h55),
           mk(3'b000, 1'b0, 1'b0, 2'b10, 8'h55)};
    bx = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    foreach (st[j]) begin
      {i_rst, i_stall, i_req} = st[j];
      sb_q.push_back(ex[j]);
      @(posedge i_clk); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %h expected %h", j, obs(), want);
      end
      n_checks++;
      if (o_busy !== bx[j]) begin
        n_fail++;
        $display("FAIL stall_busy[%0d]: got %b expected %b", j, o_busy, bx[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] st [9];
    exp_t       ex [9];
    exp_t       want;
    i_addr  = {2'b01, 2'b10, 2'b00};
    i_wdata = {8'h77, 8'h66, 8'h88};
    st = '{5'b10000, 5'b00100, 5'b10100, 5'b00100, 5'b00000,
           5'b00001, 5'b10000, 5'b00011, 5'b00000};
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b100, 1'b0, 1'b1, 2'b01, 8'h77),
           mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b100, 1'b0, 1'b1, 2'b01, 8'h77),
           mk(3'b000, 1'b0, 1'b0, 2'b01, 8'h77), mk(3'b001, 1'b0, 1'b1, 2'b00, 8'h88),
           mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b001, 1'b0, 1'b1, 2'b00, 8'h88),
           mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h88)};
    foreach (st[j]) begin
      {i_rst, i_stall, i_req} = st[j];
      sb_q.push_back(ex[j]);
      @(posedge i_clk); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got %h expected %h", j, obs(), want);
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] st [5];
    exp_t       ex [5];
    exp_t       want;
    i_addr  = {2'b01, 2'b10, 2'b00};
    i_wdata = {8'h77, 8'h66, 8'h88};
    st = '{5'b10000, 5'b00100, 5'b00000, 5'b00101, 5'b00000};
    ex = '{mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h00), mk(3'b100, 1'b0, 1'b1, 2'b01, 8'h77),
           mk(3'b000, 1'b0, 1'b0, 2'b01, 8'h77), mk(3'b001, 1'b0, 1'b1, 2'b00, 8'h88),
           mk(3'b000, 1'b0, 1'b0, 2'b00, 8'h88)};
    foreach (st[j]) begin
      {i_rst, i_stall, i_req} = st[j];
      sb_q.push_back(ex[j]);
      @(posedge i_clk); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h expected %h", j, obs(), want);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b1;
    i_stall  = 1'b0;
    i_req    = 3'b000;
    i_addr   = '0;
    i_wdata  = '0;
    @(posedge i_clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_all_three();
    test_err();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
